alpha_timer: RTL and testbench
==============================

# alpha_timer

Memory-mapped down-counting timer that answers on the SoC external `iomem_*` bus. The core acts as the initiator, and this block responds inside a 256-byte window at `BASE_ADDR`. It provides a 16-bit prescaler, a 32-bit counter with optional auto-reload, and a level interrupt intended for one of the SoC `irq_5`..`irq_7` inputs. It gives firmware a periodic tick without polling.

## Interface
- `BASE_ADDR`, default 32'h0300_0000: window base. Only bits [31:8] are compared; bits [7:0] of the parameter are ignored.
- `clk`, input, 1: system clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `iomem_valid`, input, 1: initiator request; held until `iomem_ready` is sampled high.
- `iomem_ready`, output, 1: one-cycle acknowledge pulse.
- `iomem_wstrb`, input, 4: byte write strobes; 0 means read.
- `iomem_addr`, input, 32: byte address.
- `iomem_wdata`, input, 32: write data.
- `iomem_rdata`, output, 32: read data, valid while `iomem_ready`=1.
- `irq`, output, 1: level interrupt, equal to `EXPIRED & IRQEN`.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8]`. Outside the window, `iomem_ready` stays 0.
- Register map, by offset in `addr[7:0]`; `addr[1:0]` is ignored:
  - 0x00 CTRL: bit0 EN, bit1 AUTO, bit2 IRQEN. Other bits read 0. Written only when `wstrb[0]`=1.
  - 0x04 STATUS: bit0 EXPIRED. Writing 1 to bit0 with `wstrb[0]`=1 clears it; writing 0 has no effect.
  - 0x08 LOAD: 32-bit reload value, byte-strobed.
  - 0x0C COUNT: current count, byte-strobed write.
  - 0x10 PRESCALE: bits [15:0], byte-strobed on `wstrb[1:0]`. Bits [31:16] read 0.
  - Any other offset: reads 0, writes ignored, still acknowledged.
- Prescaler `pcnt` (16 bit):
  - Runs only while EN=1.
  - When `pcnt == PRESCALE`: `tick`=1 and `pcnt` returns to 0. Otherwise `pcnt` increments.
  - `pcnt` is forced to 0 while EN=0.
- On `tick`:
  - If COUNT != 0: COUNT decrements by 1.
  - If COUNT == 0: EXPIRED is set. Then, if AUTO=1, COUNT is loaded from LOAD; if AUTO=0, EN is cleared and COUNT stays 0.
- With AUTO=1, EXPIRED sets every (LOAD+1)×(PRESCALE+1) cycles.
- Simultaneous events on the same edge:
  - A bus write to COUNT overrides both decrement and reload.
  - A bus write to CTRL overrides the hardware clear of EN.
  - A hardware set of EXPIRED overrides a write-1-to-clear.
  - A bus write to PRESCALE takes effect on the next prescaler compare.

## Timing
- Access edge: the first rising edge at which `sel && !iomem_ready`. On that edge:
  - `iomem_ready` is set to 1.
  - `iomem_rdata` is registered from the pre-edge register values.
  - The write, if any, is committed.
- The cycle after an access edge, `iomem_ready`=1 for exactly one cycle, and is then cleared by `ready <= sel && !ready`. The result is 1 wait state: request at cycle N, ready in cycle N+1.
- A held `iomem_valid` produces at most one write per ready pulse. Back-to-back requests are acknowledged every 2 cycles.
- `iomem_rdata` holds its value until the next access edge.
- `irq` is registered; it goes high the cycle after EXPIRED sets and low the cycle after the clear.
- Reset values:
  - `iomem_ready`=0, `iomem_rdata`=0, `irq`=0.
  - CTRL, STATUS, LOAD, COUNT, PRESCALE and `pcnt` all 0.
- Reset asserted mid-transaction drops `iomem_ready` to 0 on the next edge, and no write is committed.

## Test plan
- Reset, then read 0x00, 0x04, 0x08, 0x0C and 0x10 → each returns 0; each `iomem_ready` pulse is 1 cycle wide and arrives 1 cycle after valid.
- Write LOAD=3 and COUNT=3, PRESCALE=1, CTRL=0x7 → EXPIRED sets 8 cycles after the CTRL write, `irq` rises 1 cycle later, and EXPIRED repeats every 8 cycles.
- One-shot: COUNT=2, PRESCALE=0, CTRL=0x5 → EXPIRED sets after 3 cycles, CTRL reads 0x4 (EN cleared), COUNT stays 0.
- Write 0x1 to STATUS → `irq` falls next cycle. A write-1 coinciding with an expire tick → EXPIRED remains 1.
- Write 0x0000_AB00 to 0x08 with `wstrb`=4'b0010 after LOAD=0xFFFF_FFFF → LOAD reads 0xFFFF_ABFF.
- Access 0x0400_0000 → `iomem_ready` never asserts over 10 cycles. Access BASE+0x20 → reads 0, acknowledged. Assert `reset` during a pending write → no register change.

Source files
------------

// File: rtl/alpha_timer.sv
// alpha_timer: memory-mapped 32-bit down-counting timer with a 16-bit prescaler,
// optional auto-reload and a level interrupt, answering on the iomem bus.
module alpha_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_STATUS   = 6'h01;
  localparam logic [5:0] OFF_LOAD     = 6'h02;
  localparam logic [5:0] OFF_COUNT    = 6'h03;
  localparam logic [5:0] OFF_PRESCALE = 6'h04;

  // Handshake: the initiator holds iomem_valid until it samples iomem_ready
  // high. The access edge is the first edge with sel && !iomem_ready; ready
  // follows one cycle later for exactly one cycle, carrying the read data.
  logic        sel;
  logic        access;
  logic        wr;
  logic [5:0]  word;

  logic        en;
  logic        auto_rl;
  logic        irq_en;
  logic        expired;
  logic [31:0] load_val;
  logic [31:0] count_val;
  logic [15:0] prescale;
  logic [15:0] pcnt;

  logic        tick;
  logic        expire;
  logic        ctrl_wr;
  logic        status_clr;
  logic        load_wr;
  logic        count_wr;
  logic        prescale_wr;
  logic [31:0] read_data;
  logic        unused_addr_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = wd[b*8 +: 8];
    end
    return res;
  endfunction

  assign sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign access = sel && !iomem_ready;
  assign wr     = access && (iomem_wstrb != 4'b0000);
  assign word   = iomem_addr[7:2];

  assign unused_addr_bits = ^iomem_addr[1:0];

  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count_val == 32'd0);

  always_comb begin
    ctrl_wr     = 1'b0;
    status_clr  = 1'b0;
    load_wr     = 1'b0;
    count_wr    = 1'b0;
    prescale_wr = 1'b0;
    if (wr) begin
      case (word)
        OFF_CTRL:     ctrl_wr     = iomem_wstrb[0];
        OFF_STATUS:   status_clr  = iomem_wstrb[0] && iomem_wdata[0];
        OFF_LOAD:     load_wr     = 1'b1;
        OFF_COUNT:    count_wr    = 1'b1;
        OFF_PRESCALE: prescale_wr = |iomem_wstrb[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    case (word)
      OFF_CTRL:     read_data = {29'd0, irq_en, auto_rl, en};
      OFF_STATUS:   read_data = {31'd0, expired};
      OFF_LOAD:     read_data = load_val;
      OFF_COUNT:    read_data = count_val;
      OFF_PRESCALE: read_data = {16'd0, prescale};
      default:      read_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= sel && !iomem_ready;
      if (access) iomem_rdata <= read_data;
    end
  end

  // A CTRL write wins over the one-shot clear of EN on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      irq_en  <= 1'b0;
    end else if (ctrl_wr) begin
      en      <= iomem_wdata[0];
      auto_rl <= iomem_wdata[1];
      irq_en  <= iomem_wdata[2];
    end else if (expire && !auto_rl) begin
      en <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (status_clr) begin
      expired <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_val <= '0;
    end else if (load_wr) begin
      load_val <= byte_merge(load_val, iomem_wdata, iomem_wstrb);
    end
  end

  // A bus write to COUNT wins over both decrement and reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_val <= '0;
    end else if (count_wr) begin
      count_val <= byte_merge(count_val, iomem_wdata, iomem_wstrb);
    end else if (tick) begin
      if (count_val != 32'd0) begin
        count_val <= count_val - 32'd1;
      end else if (auto_rl) begin
        count_val <= load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
    end else if (prescale_wr) begin
      if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
      if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      pcnt <= '0;
    end else if (pcnt == prescale) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= expired && irq_en;
    end
  end

endmodule

// File: tb/tb_alpha_timer.sv
// Self-checking bench for alpha_timer: directed timing scenarios plus randomized
// register traffic and timer configurations checked against arithmetic expectations.
module tb_alpha_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_LOAD = BASE + 32'h08;
  localparam logic [31:0] A_CNT  = BASE + 32'h0C;
  localparam logic [31:0] A_PRE  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference register file
  logic [2:0]  m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_count;
  logic [15:0] m_pre;

  alpha_timer #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    m_ctrl  = '0;
    m_load  = '0;
    m_count = '0;
    m_pre   = '0;
  endtask

  // One bus transaction; acc_edge is the index of the clock edge that accepted it.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd, output int acc_edge);
    int k;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (iomem_ready) break;
    end
    check_eq("ack_latency", k, 0);
    rd          = iomem_rdata;
    acc_edge    = cyc;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check_eq("ack_width", {31'd0, iomem_ready}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                    output int acc_edge);
    logic [31:0] dummy;
    bus(addr, strb, wd, dummy, acc_edge);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int e;
    bus(addr, 4'h0, 32'h0, rd, e);
    check_eq(tag, rd, exp);
  endtask

  task automatic wait_irq(input int budget, output int edge_n);
    edge_n = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq) begin
        edge_n = cyc;
        return;
      end
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return {29'd0, m_ctrl};
      2: return m_load;
      3: return m_count;
      4: return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, ea, ew, r, x, seen;
    int pre, ld, cnt, per;
    logic [31:0] rd, d;
    logic [3:0]  s;
    int idx;

    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    iomem_addr = '0; iomem_wdata = '0;
    do_reset();

    // reset state
    check_eq("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check_eq("rst_rdata", iomem_rdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_stat", A_STAT, 32'd0);
    rd_chk("rst_load", A_LOAD, 32'd0);
    rd_chk("rst_count", A_CNT, 32'd0);
    rd_chk("rst_pre", A_PRE, 32'd0);

    // auto-reload: LOAD=3, COUNT=3, PRESCALE=1 gives an 8-cycle period
    wr(A_LOAD, 4'hF, 32'd3, ea);
    wr(A_CNT, 4'hF, 32'd3, ea);
    wr(A_PRE, 4'hF, 32'd1, ea);
    wr(A_CTRL, 4'hF, 32'h7, e0);
    for (int p = 0; p < 3; p++) begin
      wait_irq(60, r);
      check_eq("auto_irq_rise", r, e0 + 9 + 8 * p);
      wr(A_STAT, 4'h1, 32'h1, ea);
      check_eq("auto_irq_fall", {31'd0, irq}, 32'd0);
    end
    wr(A_CTRL, 4'hF, 32'h0, ea);
    wr(A_STAT, 4'h1, 32'h1, ea);

    // randomized auto-reload configurations
    for (int it = 0; it < 4; it++) begin
      pre = $urandom_range(0, 3);
      do ld = $urandom_range(1, 6); while ((ld + 1) * (pre + 1) < 6);
      cnt = $urandom_range(0, 5);
      per = (ld + 1) * (pre + 1);
      check_eq("rnd_irq_idle", {31'd0, irq}, 32'd0);
      wr(A_LOAD, 4'hF, ld, ea);
      wr(A_CNT, 4'hF, cnt, ea);
      wr(A_PRE, 4'hF, pre, ea);
      wr(A_CTRL, 4'hF, 32'h7, e0);
      wait_irq(100, r);
      check_eq("rnd_first_expire", r, e0 + (cnt + 1) * (pre + 1) + 1);
      x = r;
      wr(A_STAT, 4'h1, 32'h1, ea);
      wait_irq(100, r);
      check_eq("rnd_period", r, x + per);
      wr(A_CTRL, 4'hF, 32'h0, ea);
      wr(A_STAT, 4'h1, 32'h1, ea);
    end

    // one-shot: COUNT=2, PRESCALE=0
    do_reset();
    wr(A_CNT, 4'hF, 32'd2, ea);
    wr(A_CTRL, 4'hF, 32'h5, e0);
    wait_irq(40, r);
    check_eq("oneshot_irq_rise", r, e0 + 4);
    rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
    rd_chk("oneshot_count", A_CNT, 32'd0);
    rd_chk("oneshot_stat", A_STAT, 32'd1);
    wr(A_STAT, 4'h1, 32'h1, ea);
    check_eq("w1c_irq_fall", {31'd0, irq}, 32'd0);
    rd_chk("w1c_stat", A_STAT, 32'd0);

    // write-1-to-clear on the same edge as an expire
    wr(A_CNT, 4'hF, 32'd2, ea);
    wr(A_CTRL, 4'hF, 32'h5, e0);
    x = e0 + 3;
    wr(A_STAT, 4'h1, 32'h1, ea);
    rd_chk("clr_vs_expire", A_STAT, (ea > x) ? 32'd0 : 32'd1);
    wr(A_STAT, 4'h1, 32'h1, ea);

    // COUNT write overrides a running decrement
    wr(A_CNT, 4'hF, 32'd100, ea);
    wr(A_CTRL, 4'hF, 32'h5, e0);
    wr(A_CNT, 4'hF, 32'd1, ew);
    wait_irq(40, r);
    check_eq("count_override", r, ew + 3);
    wr(A_STAT, 4'h1, 32'h1, ea);

    // byte strobes on LOAD
    wr(A_LOAD, 4'hF, 32'hFFFF_FFFF, ea);
    wr(A_LOAD, 4'b0010, 32'h0000_AB00, ea);
    rd_chk("load_bytestrobe", A_LOAD, 32'hFFFF_ABFF);

    // randomized register traffic with the timer stopped
    do_reset();
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 7) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        if (idx == 0) d[0] = 1'b0;
        wr(BASE + idx * 4 + $urandom_range(0, 3), s, d, ea);
        case (idx)
          0: if (s[0]) m_ctrl = d[2:0];
          2: m_load = merge(m_load, d, s);
          3: m_count = merge(m_count, d, s);
          4: m_pre = 16'(merge({16'd0, m_pre}, d, {2'b00, s[1:0]}));
          default: ;
        endcase
      end else begin
        rd_chk("rnd_reg_read", BASE + idx * 4 + $urandom_range(0, 3), model_read(idx));
      end
    end
    for (int i = 0; i < 5; i++) rd_chk("rnd_reg_final", BASE + i * 4, model_read(i));

    // outside the window: no acknowledge
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (iomem_ready) seen = 1;
    end
    iomem_valid = 1'b0;
    check_eq("out_of_window", seen, 0);

    // unmapped offset inside the window reads 0
    wr(A_LOAD, 4'hF, 32'h1234_5678, ea);
    rd_chk("pre_unmapped_load", A_LOAD, 32'h1234_5678);
    rd_chk("unmapped_read", BASE + 32'h20, 32'd0);

    // reset during a pending write
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = A_PRE; iomem_wstrb = 4'hF; iomem_wdata = 32'h0000_BEEF;
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ready", {31'd0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    rd_chk("rst_mid_pre", A_PRE, 32'd0);
    rd_chk("rst_mid_load", A_LOAD, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
